mc_control_fsm: RTL and testbench

MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

---
 rtl/mc_control_fsm.sv | 185 ++++++++++++++++++
 tb/tb_mc_control_fsm.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multi-cycle RISC-V style control FSM with retire counter and memory timeout trap.
// Define CTRL_ILLEGAL_TRAP_EN to send unknown opcodes to TRAP instead of back to FETCH.
module mc_control_fsm #(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned MEM_TIMEOUT = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       instruction_opcode,
    input  logic             mem_ready,
    input  logic             trap_ack,
    output logic             pc_write,
    output logic             ir_write,
    output logic             pc_source,
    output logic             reg_write,
    output logic             memory_read,
    output logic             is_immediate,
    output logic             memory_write,
    output logic             pc_write_cond,
    output logic             lorD,
    output logic             memory_to_reg,
    output logic [1:0]       aluop,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic             instr_done,
    output logic [CNT_W-1:0] retire_count,
    output logic             trap,
    output logic             bus_error
);
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWRITE, S_MEMWB, S_EXEC_R, S_EXEC_I,
        S_ALUWB, S_BRANCH, S_JAL, S_JALR_ADDR, S_JALR, S_AUIPC, S_LUI, S_TRAP
    } state_e;

`ifdef CTRL_ILLEGAL_TRAP_EN
    localparam state_e ILL_NEXT = S_TRAP;
`else
    localparam state_e ILL_NEXT = S_FETCH;
`endif
    localparam logic [15:0] TMO_LAST = 16'(MEM_TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [15:0]      wait_q, wait_d;
    logic [CNT_W-1:0] retire_q, retire_d;
    logic             berr_q, berr_d;
    logic             is_wait, timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_FETCH;
            wait_q   <= '0;
            retire_q <= '0;
            berr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            retire_q <= retire_d;
            berr_q   <= berr_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        berr_d        = berr_q;
        pc_write      = 1'b0;
        ir_write      = 1'b0;
        pc_source     = 1'b0;
        reg_write     = 1'b0;
        memory_read   = 1'b0;
        is_immediate  = 1'b0;
        memory_write  = 1'b0;
        pc_write_cond = 1'b0;
        lorD          = 1'b0;
        memory_to_reg = 1'b0;
        aluop         = 2'b00;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        instr_done    = 1'b0;
        trap          = 1'b0;
        case (state_q)
            S_FETCH: begin
                memory_read = 1'b1;
                alu_src_b   = 2'b01;
                ir_write    = mem_ready;
                pc_write    = mem_ready;
                state_d     = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b10;
                case (instruction_opcode)
                    7'b0000011, 7'b0100011: state_d = S_MEMADR;
                    7'b0110011:             state_d = S_EXEC_R;
                    7'b0010011:             state_d = S_EXEC_I;
                    7'b1100011:             state_d = S_BRANCH;
                    7'b1101111:             state_d = S_JAL;
                    7'b1100111:             state_d = S_JALR_ADDR;
                    7'b0010111:             state_d = S_AUIPC;
                    7'b0110111:             state_d = S_LUI;
                    default:                state_d = ILL_NEXT;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                state_d   = (instruction_opcode == 7'b0000011) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                memory_read = 1'b1;
                lorD        = 1'b1;
                state_d     = mem_ready ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWRITE: begin
                memory_write = 1'b1;
                lorD         = 1'b1;
                instr_done   = mem_ready;
                state_d      = mem_ready ? S_FETCH : S_MEMWRITE;
            end
            S_MEMWB: begin
                memory_to_reg = 1'b1;
                reg_write     = 1'b1;
                instr_done    = 1'b1;
                state_d       = S_FETCH;
            end
            S_EXEC_R, S_EXEC_I: begin
                alu_src_a    = 2'b01;
                alu_src_b    = (state_q == S_EXEC_I) ? 2'b10 : 2'b00;
                aluop        = 2'b10;
                is_immediate = (state_q == S_EXEC_I);
                state_d      = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a     = 2'b01;
                aluop         = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 1'b1;
                instr_done    = 1'b1;
                state_d       = S_FETCH;
            end
            S_JAL, S_JALR: begin
                alu_src_a    = 2'b10;
                alu_src_b    = 2'b01;
                pc_source    = 1'b1;
                pc_write     = 1'b1;
                is_immediate = (state_q == S_JALR);
                state_d      = S_ALUWB;
            end
            S_JALR_ADDR: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                state_d   = S_JALR;
            end
            S_AUIPC, S_LUI: begin
                alu_src_a = (state_q == S_LUI) ? 2'b11 : 2'b10;
                alu_src_b = 2'b10;
                state_d   = S_ALUWB;
            end
            S_TRAP: begin
                trap = 1'b1;
                if (trap_ack) begin
                    state_d = S_FETCH;
                    berr_d  = 1'b0;
                end
            end
            default: state_d = S_FETCH;
        endcase
        // A ready on the last allowed cycle completes normally; only a still-idle bus traps.
        if (timeout) begin
            state_d = S_TRAP;
            berr_d  = 1'b1;
        end
    end

    assign is_wait      = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);
    assign timeout      = (MEM_TIMEOUT != 0) && is_wait && !mem_ready && (wait_q == TMO_LAST);
    assign wait_d       = (is_wait && state_d == state_q) ? wait_q + 16'd1 : 16'd0;
    assign retire_d     = instr_done ? retire_q + CNT_W'(1) : retire_q;
    assign retire_count = retire_q;
    assign bus_error    = berr_q;
endmodule

// File: tb/tb_mc_control_fsm.sv
// tb_mc_control_fsm: vector table plus hand sequences for timeout, wrap and async reset.
module tb_mc_control_fsm;
    localparam logic [6:0] OP_LD = 7'b0000011, OP_ST = 7'b0100011, OP_R = 7'b0110011,
        OP_I = 7'b0010011, OP_B = 7'b1100011, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111,
        OP_AUI = 7'b0010111, OP_LUI = 7'b0110111, OP_BAD = 7'b1111111;

    localparam logic [18:0] PCW = 19'h40000, IRW = 19'h20000, PCS = 19'h10000, RW = 19'h08000,
        MR = 19'h04000, IMM = 19'h02000, MW = 19'h01000, PWC = 19'h00800, LORD = 19'h00400,
        M2R = 19'h00200, DN = 19'h00004, TR = 19'h00002, BE = 19'h00001;

    function automatic logic [18:0] sel(input logic [1:0] op, input logic [1:0] a, input logic [1:0] b);
        return {10'b0, op, a, b, 3'b0};
    endfunction

    localparam logic [18:0] E_FW = MR | sel(2'b00, 2'b00, 2'b01);
    localparam logic [18:0] E_FR = E_FW | PCW | IRW;
    localparam logic [18:0] E_DEC = sel(2'b00, 2'b10, 2'b10);
    localparam logic [18:0] E_MA = sel(2'b00, 2'b01, 2'b10);
    localparam logic [18:0] E_MRD = MR | LORD;
    localparam logic [18:0] E_MWR = MW | LORD;
    localparam logic [18:0] E_MWB = M2R | RW | DN;
    localparam logic [18:0] E_EXR = sel(2'b10, 2'b01, 2'b00);
    localparam logic [18:0] E_EXI = sel(2'b10, 2'b01, 2'b10) | IMM;
    localparam logic [18:0] E_AWB = RW | DN;
    localparam logic [18:0] E_BR = sel(2'b01, 2'b01, 2'b00) | PWC | PCS | DN;
    localparam logic [18:0] E_JAL = sel(2'b00, 2'b10, 2'b01) | PCS | PCW;
    localparam logic [18:0] E_JA = sel(2'b00, 2'b01, 2'b10);
    localparam logic [18:0] E_JALR = E_JAL | IMM;
    localparam logic [18:0] E_AUI = sel(2'b00, 2'b10, 2'b10);
    localparam logic [18:0] E_LUI = sel(2'b00, 2'b11, 2'b10);

    logic clk = 1'b0, rst_n = 1'b0, mem_ready = 1'b0, trap_ack = 1'b0;
    logic [6:0] opcode = 7'b0;
    logic pc_write, ir_write, pc_source, reg_write, memory_read, is_immediate, memory_write;
    logic pc_write_cond, lorD, memory_to_reg, instr_done, trap, bus_error;
    logic [1:0] aluop, alu_src_a, alu_src_b;
    logic [7:0] retire_count;
    logic [18:0] act;
    int errors = 0, checks = 0;

    typedef struct {
        logic [6:0]  op;
        logic        rdy;
        logic        ack;
        logic [18:0] ex;
        logic [7:0]  cnt;
    } vec_t;
    vec_t tbl[$];
    logic [26:0] sb[$];

    always #5 clk = ~clk;

    mc_control_fsm #(.CNT_W(8), .MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .instruction_opcode(opcode), .mem_ready(mem_ready),
        .trap_ack(trap_ack), .pc_write(pc_write), .ir_write(ir_write), .pc_source(pc_source),
        .reg_write(reg_write), .memory_read(memory_read), .is_immediate(is_immediate),
        .memory_write(memory_write), .pc_write_cond(pc_write_cond), .lorD(lorD),
        .memory_to_reg(memory_to_reg), .aluop(aluop), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .instr_done(instr_done), .retire_count(retire_count),
        .trap(trap), .bus_error(bus_error)
    );

    assign act = {pc_write, ir_write, pc_source, reg_write, memory_read, is_immediate,
                  memory_write, pc_write_cond, lorD, memory_to_reg, aluop, alu_src_a,
                  alu_src_b, instr_done, trap, bus_error};

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, got, want);
        end
    endtask

    task automatic step(input logic [6:0] op, input logic rdy, input logic ack,
                        input logic [18:0] ex, input logic [7:0] ec, input string nm);
        logic [26:0] e;
        @(posedge clk);
        #1;
        opcode = op;
        mem_ready = rdy;
        trap_ack = ack;
        sb.push_back({ex, ec});
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        if (act !== e[26:8]) begin
            errors++;
            $display("FAIL %s ctl: got %b want %b", nm, act, e[26:8]);
        end
        chk({nm, " cnt"}, 32'(retire_count), 32'(e[7:0]));
    endtask

    task automatic add(input logic [6:0] o, input logic r, input logic a, input logic [18:0] e,
                       input logic [7:0] c);
        tbl.push_back('{o, r, a, e, c});
    endtask

    task automatic run_lui(input logic [7:0] c);
        step(OP_LUI, 1'b1, 1'b0, E_FR, c, "lui fetch");
        step(OP_LUI, 1'b1, 1'b0, E_DEC, c, "lui decode");
        step(OP_LUI, 1'b1, 1'b0, E_LUI, c, "lui exec");
        step(OP_LUI, 1'b1, 1'b0, E_AWB, c, "lui wb");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] c;
        add(OP_R, 1, 0, E_FR, 0);   add(OP_R, 1, 0, E_DEC, 0);
        add(OP_R, 1, 1, E_EXR, 0);  add(OP_R, 1, 0, E_AWB, 0);
        add(OP_LD, 1, 0, E_FR, 1);  add(OP_LD, 1, 0, E_DEC, 1);  add(OP_LD, 1, 0, E_MA, 1);
        add(OP_LD, 0, 0, E_MRD, 1); add(OP_LD, 0, 0, E_MRD, 1);  add(OP_LD, 0, 0, E_MRD, 1);
        add(OP_LD, 1, 0, E_MRD, 1); add(OP_LD, 1, 0, E_MWB, 1);
        add(OP_ST, 1, 0, E_FR, 2);  add(OP_ST, 1, 0, E_DEC, 2);  add(OP_ST, 1, 0, E_MA, 2);
        add(OP_ST, 0, 0, E_MWR, 2); add(OP_ST, 1, 0, E_MWR | DN, 2);
        add(OP_I, 1, 0, E_FR, 3);   add(OP_I, 1, 0, E_DEC, 3);
        add(OP_I, 1, 0, E_EXI, 3);  add(OP_I, 1, 0, E_AWB, 3);
        add(OP_B, 1, 0, E_FR, 4);   add(OP_B, 1, 0, E_DEC, 4);   add(OP_B, 1, 0, E_BR, 4);
        add(OP_JAL, 1, 0, E_FR, 5); add(OP_JAL, 1, 0, E_DEC, 5);
        add(OP_JAL, 1, 0, E_JAL, 5); add(OP_JAL, 1, 0, E_AWB, 5);
        add(OP_JALR, 1, 0, E_FR, 6); add(OP_JALR, 1, 0, E_DEC, 6); add(OP_JALR, 1, 0, E_JA, 6);
        add(OP_JALR, 1, 0, E_JALR, 6); add(OP_JALR, 1, 0, E_AWB, 6);
        add(OP_AUI, 1, 0, E_FR, 7); add(OP_AUI, 1, 0, E_DEC, 7);
        add(OP_AUI, 1, 0, E_AUI, 7); add(OP_AUI, 1, 0, E_AWB, 7);
        add(OP_LUI, 1, 0, E_FR, 8); add(OP_LUI, 1, 0, E_DEC, 8);
        add(OP_LUI, 1, 0, E_LUI, 8); add(OP_LUI, 1, 0, E_AWB, 8);
        add(OP_BAD, 0, 0, E_FW, 9); add(OP_BAD, 0, 0, E_FW, 9);  add(OP_BAD, 0, 0, E_FW, 9);
        add(OP_BAD, 1, 0, E_FR, 9); add(OP_BAD, 1, 0, E_DEC, 9);
`ifdef CTRL_ILLEGAL_TRAP_EN
        add(OP_BAD, 1, 0, TR, 9);   add(OP_BAD, 1, 1, TR, 9);
`endif

        #12;
        chk("rst trap", 32'(trap), 0);
        chk("rst done", 32'(instr_done), 0);
        chk("rst berr", 32'(bus_error), 0);
        chk("rst cnt", 32'(retire_count), 0);
        chk("rst mw", 32'(memory_write), 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) step(tbl[i].op, tbl[i].rdy, tbl[i].ack, tbl[i].ex, tbl[i].cnt, $sformatf("vec%0d", i));

        for (int i = 0; i < 4; i++) step(OP_LUI, 1'b0, 1'b0, E_FW, 9, $sformatf("tmo wait%0d", i));
        step(OP_LUI, 1'b0, 1'b0, TR | BE, 9, "tmo trap");
        step(OP_LUI, 1'b0, 1'b1, TR | BE, 9, "tmo ack");
        step(OP_LUI, 1'b0, 1'b0, E_FW, 9, "ready wins w0");
        step(OP_LUI, 1'b0, 1'b0, E_FW, 9, "ready wins w1");
        step(OP_LUI, 1'b0, 1'b0, E_FW, 9, "ready wins w2");
        step(OP_LUI, 1'b1, 1'b0, E_FR, 9, "ready wins go");
        step(OP_LUI, 1'b1, 1'b0, E_DEC, 9, "ready wins dec");
        step(OP_LUI, 1'b1, 1'b0, E_LUI, 9, "ready wins lui");
        step(OP_LUI, 1'b1, 1'b0, E_AWB, 9, "ready wins wb");

        c = 8'd10;
        for (int i = 0; i < 246; i++) begin
            run_lui(c);
            c = c + 8'd1;
        end

        step(OP_ST, 1'b1, 1'b0, E_FR, c, "wrap fetch");
        step(OP_ST, 1'b1, 1'b0, E_DEC, 0, "st decode");
        step(OP_ST, 1'b1, 1'b0, E_MA, 0, "st memadr");
        step(OP_ST, 1'b0, 1'b0, E_MWR, 0, "st memwrite");
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst mw", 32'(memory_write), 0);
        chk("midrst done", 32'(instr_done), 0);
        chk("midrst trap", 32'(trap), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(OP_R, 1'b0, 1'b0, E_FW, 0, "postrst wait");
        step(OP_R, 1'b1, 1'b0, E_FR, 0, "postrst fetch");
        step(OP_R, 1'b1, 1'b0, E_DEC, 0, "postrst decode");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
